// File: rtl/icmp_echo_engine.sv
// rtl/icmp_echo_engine.sv - store-and-forward ICMP echo responder on byte-wide AXI-Stream
// Define ICMP_IP_FILTER_EN to also require destination IP == LOCAL_IP.
module icmp_echo_engine #(
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_00,
  parameter logic [31:0] LOCAL_IP  = 32'hC0_A8_01_80,
  parameter int          BUF_DEPTH = 2048,
  parameter int          LED_HOLD  = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tlast,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  input  logic       m_axis_tready,
  output logic       ping_detect
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int LW = $clog2(LED_HOLD + 1);

  localparam logic [1:0] ST_RX       = 2'd0;
  localparam logic [1:0] ST_DROP     = 2'd1;
  localparam logic [1:0] ST_TX_PRIME = 2'd2;
  localparam logic [1:0] ST_TX       = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] last_q, last_d;
  logic [47:0]   src_mac_q, src_mac_d;
  logic [15:0]   etype_q, etype_d;
  logic [7:0]    proto_q, proto_d;
  logic [31:0]   src_ip_q, src_ip_d;
  logic [31:0]   dst_ip_q, dst_ip_d;
  logic [7:0]    icmp_type_q, icmp_type_d;
  logic [15:0]   cksum_q, cksum_d;
  logic [LW-1:0] led_q, led_d;

  logic [7:0]    mem [BUF_DEPTH];
  logic [7:0]    rd_data_q;
  logic [AW-1:0] rd_addr;
  logic          rx_hs, tx_hs, tx_active, wr_en, dst_ok, frame_ok;
  logic [16:0]   ck_sum;
  logic [15:0]   ck_new;
  int            k;

  function automatic logic [7:0] byte_of48(input logic [47:0] v, input int i);
    logic [47:0] s;
    s = v >> (8 * (5 - i));
    return s[7:0];
  endfunction

  function automatic logic [7:0] byte_of32(input logic [31:0] v, input int i);
    logic [31:0] s;
    s = v >> (8 * (3 - i));
    return s[7:0];
  endfunction

  assign k             = int'(cnt_q);
  assign tx_active     = (state_q == ST_TX) && !rst;
  assign s_axis_tready = !rst && ((state_q == ST_RX) || (state_q == ST_DROP));
  assign m_axis_tvalid = tx_active;
  assign m_axis_tlast  = tx_active && (cnt_q == last_q);
  assign ping_detect   = (led_q != '0);
  assign rx_hs         = s_axis_tvalid && s_axis_tready;
  assign tx_hs         = m_axis_tvalid && m_axis_tready;
  assign wr_en         = rx_hs && (state_q == ST_RX);

  // Swapping the two addresses leaves the sum unchanged; only type 8->0 moves it.
  assign ck_sum = {1'b0, cksum_q} + 17'h00800;
  assign ck_new = ck_sum[15:0] + {15'd0, ck_sum[16]};

`ifdef ICMP_IP_FILTER_EN
  assign dst_ok = (dst_ip_q == LOCAL_IP);
`else
  logic unused_local_ip;
  assign unused_local_ip = ^LOCAL_IP;
  assign dst_ok = 1'b1;
`endif

  // Checked on the tlast byte, whose index is k, so length >= 42 means k >= 41.
  assign frame_ok = (k >= 41) && (etype_q == 16'h0800) && (proto_q == 8'h01) &&
                    (icmp_type_q == 8'h08) && dst_ok;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    src_mac_d   = src_mac_q;
    etype_d     = etype_q;
    proto_d     = proto_q;
    src_ip_d    = src_ip_q;
    dst_ip_d    = dst_ip_q;
    icmp_type_d = icmp_type_q;
    cksum_d     = cksum_q;
    led_d       = (led_q != '0) ? led_q - 1'b1 : led_q;
    rd_addr     = (tx_hs) ? cnt_q + 1'b1 : cnt_q;
    case (state_q)
      ST_RX: begin
        if (rx_hs) begin
          cnt_d = cnt_q + 1'b1;
          if (k >= 6 && k <= 11)  src_mac_d   = {src_mac_q[39:0], s_axis_tdata};
          if (k == 12 || k == 13) etype_d     = {etype_q[7:0], s_axis_tdata};
          if (k == 23)            proto_d     = s_axis_tdata;
          if (k >= 26 && k <= 29) src_ip_d    = {src_ip_q[23:0], s_axis_tdata};
          if (k >= 30 && k <= 33) dst_ip_d    = {dst_ip_q[23:0], s_axis_tdata};
          if (k == 34)            icmp_type_d = s_axis_tdata;
          if (k == 36 || k == 37) cksum_d     = {cksum_q[7:0], s_axis_tdata};
          if (s_axis_tlast) begin
            cnt_d = '0;
            if (frame_ok) begin
              last_d  = cnt_q;
              state_d = ST_TX_PRIME;
              led_d   = LW'(LED_HOLD);
            end
          end else if (cnt_q == AW'(BUF_DEPTH - 1)) begin
            cnt_d   = '0;
            state_d = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (rx_hs && s_axis_tlast) state_d = ST_RX;
      end
      ST_TX_PRIME: state_d = ST_TX;
      ST_TX: begin
        if (tx_hs) begin
          if (cnt_q == last_q) begin
            state_d = ST_RX;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_RX;
    endcase
  end

  always_comb begin
    m_axis_tdata = 8'h00;
    if (tx_active) begin
      m_axis_tdata = rd_data_q;
      if (k < 6)                   m_axis_tdata = byte_of48(src_mac_q, k);
      else if (k < 12)             m_axis_tdata = byte_of48(LOCAL_MAC, k - 6);
      else if (k >= 26 && k < 30)  m_axis_tdata = byte_of32(dst_ip_q, k - 26);
      else if (k >= 30 && k < 34)  m_axis_tdata = byte_of32(src_ip_q, k - 30);
      else if (k == 34)            m_axis_tdata = 8'h00;
      else if (k == 36)            m_axis_tdata = ck_new[15:8];
      else if (k == 37)            m_axis_tdata = ck_new[7:0];
    end
  end

  // Read runs one byte ahead so the next byte is ready the cycle after a handshake.
  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt_q] <= s_axis_tdata;
    rd_data_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RX;
      cnt_q       <= '0;
      last_q      <= '0;
      src_mac_q   <= '0;
      etype_q     <= '0;
      proto_q     <= '0;
      src_ip_q    <= '0;
      dst_ip_q    <= '0;
      icmp_type_q <= '0;
      cksum_q     <= '0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      src_mac_q   <= src_mac_d;
      etype_q     <= etype_d;
      proto_q     <= proto_d;
      src_ip_q    <= src_ip_d;
      dst_ip_q    <= dst_ip_d;
      icmp_type_q <= icmp_type_d;
      cksum_q     <= cksum_d;
      led_q       <= led_d;
    end
  end

endmodule

// File: tb/tb_icmp_echo_engine.sv
// tb/tb_icmp_echo_engine.sv - randomized scoreboard bench for icmp_echo_engine
module tb_icmp_echo_engine;
  localparam logic [47:0] MAC   = 48'h02_00_00_00_00_00;
  localparam logic [31:0] MY_IP = 32'hC0_A8_01_80;
  localparam int          DEPTH = 2048;
  localparam int          HOLD  = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tlast = 1'b0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic       m_axis_tready = 1'b1;
  logic       ping_detect;

  always #5 clk = ~clk;

  icmp_echo_engine #(
    .LOCAL_MAC(MAC), .LOCAL_IP(MY_IP), .BUF_DEPTH(DEPTH), .LED_HOLD(HOLD)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .ping_detect(ping_detect)
  );

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  logic [7:0] got[$];
  logic [7:0] frame[$];
  logic [7:0] ref1[$];
  int         rdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Downstream ready: 0 = always ready, 1 = random, 2 = held low.
  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
  end

  logic       pv = 1'b0, pr = 1'b0, pl = 1'b0, prst = 1'b1;
  logic [7:0] pd = 8'h00;
  logic [8:0] e;
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_reply_byte actual=%h required=none", m_axis_tdata);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("reply_byte%0d", got.size()), 32'({m_axis_tlast, m_axis_tdata}), 32'(e));
      end
      got.push_back(m_axis_tdata);
      if (m_axis_tlast) chk("ping_at_tlast", 32'(ping_detect), 32'd1);
    end
    if (pv && !pr && !rst && !prst)
      chk("stall_hold", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 32'({1'b1, pl, pd}));
    pv = m_axis_tvalid; pr = m_axis_tready; pl = m_axis_tlast; pd = m_axis_tdata; prst = rst;
  end

  task automatic push_be(input logic [87:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) frame.push_back(8'(v >> (8 * i)));
  endtask

  task automatic build(input logic [15:0] et, input logic [7:0] pro, input logic [7:0] ty,
                       input logic [15:0] ck, input logic [47:0] smac, input logic [31:0] sip,
                       input logic [31:0] dip, input int plen, input bit hello);
    logic [87:0] hw;
    hw = "Hello World";
    frame.delete();
    push_be(88'(MAC), 6);
    push_be(88'(smac), 6);
    push_be(88'(et), 2);
    push_be(88'h4500, 2);
    push_be(88'(28 + plen), 2);
    push_be(88'($urandom_range(0, 65535)), 2);
    push_be(88'h4000_40, 3);
    frame.push_back(pro);
    push_be(88'($urandom_range(0, 65535)), 2);
    push_be(88'(sip), 4);
    push_be(88'(dip), 4);
    frame.push_back(ty);
    frame.push_back(8'h00);
    push_be(88'(ck), 2);
    push_be(88'($urandom), 4);
    if (hello) push_be(hw, 11);
    else for (int i = 0; i < plen; i++) frame.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference: decide acceptance from the frame bytes, then queue the reply byte by byte.
  function automatic bit model();
    int          n;
    int          c;
    bit          ok;
    logic [7:0]  b;
    logic [47:0] lm;
    n  = frame.size();
    lm = MAC;
    ok = (n >= 42) && (n <= DEPTH) && (frame[12] == 8'h08) && (frame[13] == 8'h00) &&
         (frame[23] == 8'h01) && (frame[34] == 8'h08);
`ifdef ICMP_IP_FILTER_EN
    if (ok) ok = ({frame[30], frame[31], frame[32], frame[33]} == MY_IP);
`endif
    if (!ok) return 1'b0;
    c = int'({frame[36], frame[37]}) + 32'h0800;
    if (c > 32'hFFFF) c = c - 32'hFFFF;
    for (int i = 0; i < n; i++) begin
      b = frame[i];
      if (i < 6)                 b = frame[i + 6];
      else if (i < 12)           b = 8'(lm >> (8 * (11 - i)));
      else if (i >= 26 && i < 30) b = frame[i + 4];
      else if (i >= 30 && i < 34) b = frame[i - 4];
      else if (i == 34)          b = 8'h00;
      else if (i == 36)          b = 8'(c >> 8);
      else if (i == 37)          b = 8'(c);
      exp_q.push_back({(i == n - 1), b});
    end
    return 1'b1;
  endfunction

  task automatic send_frame(input bit gaps);
    bit ok;
    int g;
    @(posedge clk); #1;
    for (int i = 0; i < frame.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        @(posedge clk); #1;
      end
      s_axis_tdata = frame[i]; s_axis_tvalid = 1'b1; s_axis_tlast = (i == frame.size() - 1);
      g = 0;
      do begin
        @(negedge clk); ok = s_axis_tready;
        @(posedge clk); #1; g++;
      end while (!ok && g < 5000);
      if (!ok) begin
        chk("rx_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && g < 5000) begin
      @(negedge clk); g++;
    end
    chk("drain_within_budget", 32'(g < 5000), 32'd1);
  endtask

  task automatic send_and_check(input bit gaps);
    bit v;
    v = model();
    got.delete();
    send_frame(gaps);
    @(negedge clk); chk("rx_tready_after_tlast", 32'(s_axis_tready), 32'(!v));
    @(negedge clk); chk("tvalid_2_after_tlast", 32'(m_axis_tvalid), 32'(v));
    drain();
  endtask

  int mism;
  int n;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_s_tready", 32'(s_axis_tready), 32'd0);
    chk("reset_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("reset_m_tlast", 32'(m_axis_tlast), 32'd0);
    chk("reset_m_tdata", 32'(m_axis_tdata), 32'd0);
    chk("reset_ping", 32'(ping_detect), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); chk("ready_after_reset", 32'(s_axis_tready), 32'd1);

    // Non-ICMP and non-IPv4 frames are dropped silently
    build(16'h0800, 8'h11, 8'h08, 16'hAABB, 48'hAABBCCDDEEFF, 32'hC0A80132, MY_IP, 11, 1'b1);
    send_and_check(1'b0);
    build(16'h0806, 8'h01, 8'h08, 16'hAABB, 48'hAABBCCDDEEFF, 32'hC0A80132, MY_IP, 11, 1'b1);
    send_and_check(1'b0);
    chk("ping_idle_after_drops", 32'(ping_detect), 32'd0);

    build(16'h0800, 8'h01, 8'h08, 16'hAABB, 48'hAABBCCDDEEFF, 32'hC0A80132, MY_IP, 11, 1'b1);
    send_and_check(1'b0);
    chk("hello_len", 32'(got.size()), 32'd53);
    chk("hello_b0", 32'(got[0]), 32'hAA);
    chk("hello_mac", 32'({got[6], got[7], got[11]}), 32'h020000);
    chk("hello_ip", {got[26], got[27], got[28], got[29]}, 32'hC0A80180);
    chk("hello_type", 32'(got[34]), 32'h00);
    chk("hello_cksum", 32'({got[36], got[37]}), 32'hB2BB);
    chk("hello_payload", 32'({got[42], got[52]}), 32'h4864);
    ref1 = got;

    // Same frame replayed with a randomly stalling sink
    rdy_mode = 1;
    send_and_check(1'b1);
    rdy_mode = 0;
    mism = 0;
    for (int i = 0; i < ref1.size(); i++) if (got.size() <= i || got[i] !== ref1[i]) mism++;
    chk("stalled_reply_len", 32'(got.size()), 32'(ref1.size()));
    chk("stalled_reply_bytes", 32'(mism), 32'd0);

    build(16'h0800, 8'h01, 8'h08, 16'hF900, 48'h001122334455, 32'hC0A80107, MY_IP, 20, 1'b0);
    send_and_check(1'b1);
    chk("wrap_cksum", 32'({got[36], got[37]}), 32'h0101);

    build(16'h0800, 8'h01, 8'h08, 16'h1234, 48'h001122334455, 32'hC0A80107, MY_IP, 20, 1'b0);
    frame = frame[0:29];
    send_and_check(1'b0);
    build(16'h0800, 8'h01, 8'h08, 16'h1234, 48'h001122334455, 32'hC0A80107, MY_IP, 5, 1'b0);
    send_and_check(1'b0);

    // Oversized frame overflows the buffer and is discarded
    build(16'h0800, 8'h01, 8'h08, 16'h4321, 48'h0A0B0C0D0E0F, 32'hC0A80109, MY_IP, 2058, 1'b0);
    send_and_check(1'b0);
    build(16'h0800, 8'h01, 8'h08, 16'hFFFF, 48'h0A0B0C0D0E0F, 32'hC0A80109, MY_IP, 0, 1'b0);
    send_and_check(1'b1);

    repeat (HOLD + 20) @(negedge clk);
    chk("ping_expired", 32'(ping_detect), 32'd0);

    for (int t = 0; t < 14; t++) begin
      build(($urandom_range(0, 3) == 0) ? 16'h0806 : 16'h0800,
            ($urandom_range(0, 4) == 0) ? 8'h11 : 8'h01,
            ($urandom_range(0, 4) == 0) ? 8'h00 : 8'h08,
            16'($urandom_range(0, 65535)), {16'h1234, 32'($urandom)}, 32'($urandom),
            ($urandom_range(0, 5) == 0) ? 32'($urandom) : MY_IP,
            $urandom_range(0, 60), 1'b0);
      if ($urandom_range(0, 5) == 0) begin
        n = $urandom_range(14, 41);
        frame = frame[0:n-1];
      end
      rdy_mode = $urandom_range(0, 1);
      send_and_check(1'($urandom_range(0, 1)));
    end
    rdy_mode = 0;

    // Reset while reply byte 20 is on the bus
    build(16'h0800, 8'h01, 8'h08, 16'hAABB, 48'hAABBCCDDEEFF, 32'hC0A80132, MY_IP, 11, 1'b1);
    void'(model());
    got.delete();
    send_frame(1'b0);
    for (int g = 0; g < 500; g++) begin
      @(posedge clk); #1;
      if (got.size() >= 20) break;
    end
    chk("reached_byte20", 32'(got.size()), 32'd20);
    rst = 1'b1; rdy_mode = 2;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("tvalid_after_reset", 32'(m_axis_tvalid), 32'd0);
    chk("tready_after_reset", 32'(s_axis_tready), 32'd1);
    chk("ping_after_reset", 32'(ping_detect), 32'd0);
    rdy_mode = 0;
    send_and_check(1'b0);
    chk("post_reset_len", 32'(got.size()), 32'd53);
    chk("post_reset_cksum", 32'({got[36], got[37]}), 32'hB2BB);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
